ram_wr_demux: RTL and testbench

Write-side counterpart of the four-bank RAM read mux in the matrix-multiplication datapath. It accepts a stream of 18-bit matrix elements tagged with a bank select and word address, and routes each one to exactly one of four RAM banks through a registered write stage. The stage stalls on per-bank busy. A start/length/done frame brackets each matrix load, so the controller knows when all banks hold the operand.

---
 rtl/ram_wr_pkg.sv | 15 +
 rtl/ram_wr_stage.sv | 61 ++++++
 rtl/ram_wr_demux.sv | 128 ++++++++++++
 tb/tb_ram_wr_demux.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_wr_pkg.sv
// Shared types for the four-bank RAM write demux (write-side twin of the read mux).
package ram_wr_pkg;

    localparam int NUM_BANKS      = 4;
    localparam int DATA_W_DEFAULT = 18;

    typedef logic [1:0] bank_sel_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FINISH
    } state_t;

endpackage

// File: rtl/ram_wr_stage.sv
// One-entry register slice holding {sel, addr, data} between the input stream and the banks.
module ram_wr_stage
    import ram_wr_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              fire,
    input  bank_sel_t         ld_sel,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              stg_valid,
    output bank_sel_t         stg_sel,
    output logic [ADDR_W-1:0] stg_addr,
    output logic [DATA_W-1:0] stg_data
);

    logic              valid_q, valid_d;
    bank_sel_t         sel_q, sel_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;

    // A load wins over a fire: the slot is refilled in the same cycle it drains.
    always_comb begin
        valid_d = valid_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            sel_d   = ld_sel;
            addr_d  = ld_addr;
            data_d  = ld_data;
        end else if (fire) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            sel_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign stg_valid = valid_q;
    assign stg_sel   = sel_q;
    assign stg_addr  = addr_q;
    assign stg_data  = data_q;

endmodule

// File: rtl/ram_wr_demux.sv
// Routes a framed element stream to one of four RAM banks via a registered write stage.
// Optional per-bank write counters are enabled with RAM_WR_DEMUX_CNT_EN.
module ram_wr_demux
    import ram_wr_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CNT_W-1:0]     load_len,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_data,
    input  logic [ADDR_W-1:0]    in_addr,
    input  bank_sel_t            in_select,
    input  logic [NUM_BANKS-1:0] bank_busy,
    output logic [NUM_BANKS-1:0] bank_we,
    output logic [ADDR_W-1:0]    bank_addr,
    output logic [DATA_W-1:0]    bank_data,
    output logic                 busy,
    output logic                 done
`ifdef RAM_WR_DEMUX_CNT_EN
    ,
    output logic [NUM_BANKS-1:0][CNT_W-1:0] bank_wr_cnt
`endif
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;

    logic      stg_valid;
    bank_sel_t stg_sel;
    logic      stg_fire;
    logic      accept;
    logic      start_ok;

    assign stg_fire = stg_valid && !bank_busy[stg_sel];
    assign in_ready = (state_q == LOAD) && (remaining_q != '0) && (!stg_valid || stg_fire);
    assign accept   = in_valid && in_ready;
    assign start_ok = (state_q == IDLE) && start;
    assign bank_we  = stg_fire ? ({{(NUM_BANKS-1){1'b0}}, 1'b1} << stg_sel) : '0;
    assign busy     = (state_q == LOAD);
    assign done     = (state_q == FINISH);

    ram_wr_stage #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .fire      (stg_fire),
        .ld_sel    (in_select),
        .ld_addr   (in_addr),
        .ld_data   (in_data),
        .stg_valid (stg_valid),
        .stg_sel   (stg_sel),
        .stg_addr  (bank_addr),
        .stg_data  (bank_data)
    );

    // Only the final staged write can end the load, so finishing needs remaining == 0.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    remaining_d = load_len;
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    remaining_d = remaining_q - CNT_W'(1);
                end
                if ((remaining_q == '0) && (!stg_valid || stg_fire)) begin
                    state_d = FINISH;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
        end
    end

`ifdef RAM_WR_DEMUX_CNT_EN
    logic [NUM_BANKS-1:0][CNT_W-1:0] cnt_q, cnt_d;

    // Counters survive done so the controller can read them until the next load.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (start_ok) begin
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + {{(CNT_W-1){1'b0}}, bank_we[i]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bank_wr_cnt = cnt_q;
`else
    logic unused_start_ok;
    assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_ram_wr_demux.sv
// Scoreboard bench for ram_wr_demux: stimulus queues expected writes, a monitor checks them.
// Counter checks are compiled in with RAM_WR_DEMUX_CNT_EN.
module tb_ram_wr_demux;

   logic        clk;
   logic        rstN;
   logic        start;
   logic [15:0] loadLen;
   logic        inValid;
   logic        inReady;
   logic [17:0] inData;
   logic [7:0]  inAddr;
   logic [1:0]  inSelect;
   logic [3:0]  bankBusy;
   logic [3:0]  bankWe;
   logic [7:0]  bankAddr;
   logic [17:0] bankData;
   logic        busy;
   logic        done;
`ifdef RAM_WR_DEMUX_CNT_EN
   logic [3:0][15:0] bankWrCnt;
`endif

   typedef struct {
      logic [3:0]  we;
      logic [7:0]  addr;
      logic [17:0] data;
      int          cycle;
   } wrEntry_t;

   wrEntry_t sbQ[$];
   int checks = 0;
   int errors = 0;
   int cycleCount = 0;

   ram_wr_demux dut (
      .clk       (clk),
      .rst_n     (rstN),
      .start     (start),
      .load_len  (loadLen),
      .in_valid  (inValid),
      .in_ready  (inReady),
      .in_data   (inData),
      .in_addr   (inAddr),
      .in_select (inSelect),
      .bank_busy (bankBusy),
      .bank_we   (bankWe),
      .bank_addr (bankAddr),
      .bank_data (bankData),
      .busy      (busy),
      .done      (done)
`ifdef RAM_WR_DEMUX_CNT_EN
      ,
      .bank_wr_cnt (bankWrCnt)
`endif
   );

   // Free-running clock and a cycle index used to time expected events
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cycleCount <= cycleCount + 1;

   // Single comparison point; every check in the bench goes through here
   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cycleCount);
      end
   endtask

   // Monitor: every write the DUT presents must match the head of the scoreboard
   always @(negedge clk) begin
      wrEntry_t e;
      if (bankWe != 4'b0000) begin
         if (sbQ.size() == 0) begin
            checkOutput("unexpectedWrite", {60'b0, bankWe}, 64'd0);
         end else begin
            e = sbQ.pop_front();
            checkOutput("bankWe", {60'b0, bankWe}, {60'b0, e.we});
            checkOutput("bankAddr", {56'b0, bankAddr}, {56'b0, e.addr});
            checkOutput("bankData", {46'b0, bankData}, {46'b0, e.data});
            checkOutput("writeCycle", 64'(cycleCount), 64'(e.cycle));
         end
      end
   end

   // Issues start for one cycle; called just after a rising edge
   task automatic startLoad(input logic [15:0] len, output int startCycle);
      start   = 1'b1;
      loadLen = len;
      @(negedge clk);
      startCycle = cycleCount;
      checkOutput("inReadyIdle", {63'b0, inReady}, 64'd0);
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Offers one element until accepted, queueing its expected write
   task automatic applyStimulus(input logic [1:0] sel, input logic [7:0] addr, input logic [17:0] data,
                                input int stallCycles, output int accCycle);
      wrEntry_t e;
      bit accepted = 0;
      int budget = 0;
      inValid  = 1'b1;
      inSelect = sel;
      inAddr   = addr;
      inData   = data;
      accCycle = -1;
      while (!accepted && budget < 50) begin
         @(negedge clk);
         if (inReady) begin
            accepted = 1;
            accCycle = cycleCount;
            e.we     = 4'b0001 << sel;
            e.addr   = addr;
            e.data   = data;
            e.cycle  = cycleCount + 1 + stallCycles;
            sbQ.push_back(e);
         end
         @(posedge clk);
         #1;
         budget++;
      end
      inValid = 1'b0;
      if (!accepted) checkOutput("acceptTimeout", 64'd0, 64'd1);
   endtask

   // Waits for done, checks its cycle, its single-cycle width and the return to IDLE
   task automatic waitDone(input int expCycle);
      bit seen = 0;
      int budget = 0;
      while (!seen && budget < 50) begin
         @(negedge clk);
         if (done) begin
            seen = 1;
            checkOutput("doneCycle", 64'(cycleCount), 64'(expCycle));
         end
         @(posedge clk);
         #1;
         budget++;
      end
      if (!seen) begin
         checkOutput("doneTimeout", 64'd0, 64'd1);
      end else begin
         @(negedge clk);
         checkOutput("donePulse", {63'b0, done}, 64'd0);
         checkOutput("idleBusy", {63'b0, busy}, 64'd0);
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int s, a0, a1, a2, a3;
      rstN     = 1'b0;
      start    = 1'b0;
      loadLen  = '0;
      inValid  = 1'b0;
      inData   = '0;
      inAddr   = '0;
      inSelect = '0;
      bankBusy = '0;

      // Reset values
      #3;
      checkOutput("rstInReady", {63'b0, inReady}, 64'd0);
      checkOutput("rstBankWe", {60'b0, bankWe}, 64'd0);
      checkOutput("rstBankAddr", {56'b0, bankAddr}, 64'd0);
      checkOutput("rstBankData", {46'b0, bankData}, 64'd0);
      checkOutput("rstBusy", {63'b0, busy}, 64'd0);
      checkOutput("rstDone", {63'b0, done}, 64'd0);
`ifdef RAM_WR_DEMUX_CNT_EN
      checkOutput("rstCnt", bankWrCnt, 64'd0);
`endif
      repeat (2) @(posedge clk);
      #1;
      rstN = 1'b1;
      @(posedge clk);
      #1;

      // Stream of four elements to banks 0..3 with no busy
      $display("[TB] stream, no busy");
      startLoad(16'd4, s);
      applyStimulus(2'd0, 8'd5, 18'h00011, 0, a0);
      applyStimulus(2'd1, 8'd5, 18'h00012, 0, a1);
      applyStimulus(2'd2, 8'd5, 18'h00013, 0, a2);
      applyStimulus(2'd3, 8'd5, 18'h00014, 0, a3);
      checkOutput("firstAccept", 64'(a0), 64'(s + 1));
      checkOutput("lastAccept", 64'(a3), 64'(s + 4));
      waitDone(s + 6);

      // Target bank busy for three cycles, then a same-cycle fire and refill
      $display("[TB] target busy");
      startLoad(16'd2, s);
      bankBusy = 4'b0100;
      applyStimulus(2'd2, 8'd9, 18'h3FFFF, 3, a0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("stallWe", {60'b0, bankWe}, 64'd0);
         checkOutput("stallReady", {63'b0, inReady}, 64'd0);
         @(posedge clk);
         #1;
      end
      bankBusy = 4'b0000;
      applyStimulus(2'd1, 8'd10, 18'h0ABCD, 0, a1);
      checkOutput("refillAccept", 64'(a1), 64'(s + 5));
      waitDone(s + 7);

      // Busy on the other banks must not throttle bank 0
      $display("[TB] non-target busy");
      bankBusy = 4'b1110;
      startLoad(16'd3, s);
      applyStimulus(2'd0, 8'd1, 18'h00101, 0, a0);
      applyStimulus(2'd0, 8'd2, 18'h00202, 0, a1);
      applyStimulus(2'd0, 8'd3, 18'h00303, 0, a2);
      checkOutput("ntbAccept", 64'(a2), 64'(s + 3));
      waitDone(s + 5);
      bankBusy = 4'b0000;

      // Zero-length load
      $display("[TB] zero-length load");
      startLoad(16'd0, s);
      @(negedge clk);
      checkOutput("zeroReady", {63'b0, inReady}, 64'd0);
      checkOutput("zeroBusy", {63'b0, busy}, 64'd1);
      @(posedge clk);
      #1;
      waitDone(s + 2);

      // Reset with the second of six elements sitting in the stage
      $display("[TB] reset mid-load");
      startLoad(16'd6, s);
      applyStimulus(2'd1, 8'd7, 18'h01111, 0, a0);
      applyStimulus(2'd2, 8'd8, 18'h02222, 0, a1);
      rstN = 1'b0;
      #1;
      if (sbQ.size() > 0) void'(sbQ.pop_back());
      checkOutput("midRstWe", {60'b0, bankWe}, 64'd0);
      checkOutput("midRstAddr", {56'b0, bankAddr}, 64'd0);
      checkOutput("midRstData", {46'b0, bankData}, 64'd0);
      checkOutput("midRstBusy", {63'b0, busy}, 64'd0);
      checkOutput("midRstReady", {63'b0, inReady}, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rstN = 1'b1;
      @(negedge clk);
      checkOutput("postRstBusy", {63'b0, busy}, 64'd0);
      @(posedge clk);
      #1;
      startLoad(16'd1, s);
      applyStimulus(2'd3, 8'd4, 18'h04444, 0, a0);
      waitDone(s + 3);

`ifdef RAM_WR_DEMUX_CNT_EN
      // Per-bank counters over a six-element load, then cleared by the next start
      $display("[TB] bank write counters");
      startLoad(16'd6, s);
      applyStimulus(2'd0, 8'd20, 18'h10000, 0, a0);
      applyStimulus(2'd0, 8'd21, 18'h10001, 0, a0);
      applyStimulus(2'd1, 8'd22, 18'h10002, 0, a0);
      applyStimulus(2'd3, 8'd23, 18'h10003, 0, a0);
      applyStimulus(2'd3, 8'd24, 18'h10004, 0, a0);
      applyStimulus(2'd3, 8'd25, 18'h10005, 0, a0);
      waitDone(s + 8);
      checkOutput("cntAfterLoad", bankWrCnt, {16'd3, 16'd0, 16'd1, 16'd2});
      startLoad(16'd1, s);
      checkOutput("cntCleared", bankWrCnt, 64'd0);
      applyStimulus(2'd2, 8'd30, 18'h20000, 0, a0);
      waitDone(s + 3);
      checkOutput("cntSecond", bankWrCnt, {16'd0, 16'd1, 16'd0, 16'd0});
`endif

      checkOutput("sbEmpty", 64'(sbQ.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
